// File: rtl/seed_g_serial.sv
// Byte-serial SEED G function: four bytes in (X0..X3), four bytes out (Z0..Z3).
// Bytes are S-box substituted as they arrive and folded into four mask accumulators.
module seed_g_serial (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ready
);

  localparam logic [0:0] StLoad = 1'b0;
  localparam logic [0:0] StEmit = 1'b1;

  // Mask index k selects m_k.
  localparam logic [3:0][7:0] Masks = {8'h3F, 8'hCF, 8'hF3, 8'hFC};

  localparam logic [7:0] S1Tab [256] = '{
    8'hA9, 8'h85, 8'hD6, 8'hD3, 8'h54, 8'h1D, 8'hAC, 8'h25, 8'h5D, 8'h43, 8'h18, 8'h1E, 8'h51, 8'hFC, 8'hCA, 8'h63,
    8'h28, 8'h44, 8'h20, 8'h9D, 8'hE0, 8'hE2, 8'hC8, 8'h17, 8'hA5, 8'h8F, 8'h03, 8'h7B, 8'hBB, 8'h13, 8'hD2, 8'hEE,
    8'h70, 8'h8C, 8'h3F, 8'hA8, 8'h32, 8'hDD, 8'hF6, 8'h74, 8'hEC, 8'h95, 8'h0B, 8'h57, 8'h5C, 8'h5B, 8'hBD, 8'h01,
    8'h24, 8'h1C, 8'h73, 8'h98, 8'h10, 8'hCC, 8'hF2, 8'hD9, 8'h2C, 8'hE7, 8'h72, 8'h83, 8'h9B, 8'hD1, 8'h86, 8'hC9,
    8'h60, 8'h50, 8'hA3, 8'hEB, 8'h0D, 8'hB6, 8'h9E, 8'h4F, 8'hB7, 8'h5A, 8'hC6, 8'h78, 8'hA6, 8'h12, 8'hAF, 8'hD5,
    8'h61, 8'hC3, 8'hB4, 8'h41, 8'h52, 8'h7D, 8'h8D, 8'h08, 8'h1F, 8'h99, 8'h00, 8'h19, 8'h04, 8'h53, 8'hF7, 8'hE1,
    8'hFD, 8'h76, 8'h2F, 8'h27, 8'hB0, 8'h8B, 8'h0E, 8'hAB, 8'hA2, 8'h6E, 8'h93, 8'h4D, 8'h69, 8'h7C, 8'h09, 8'h0A,
    8'hBF, 8'hEF, 8'hF3, 8'hC5, 8'h87, 8'h14, 8'hFE, 8'h64, 8'hDE, 8'h2E, 8'h4B, 8'h1A, 8'h06, 8'h21, 8'h6B, 8'h66,
    8'h02, 8'hF5, 8'h92, 8'h8A, 8'h0C, 8'hB3, 8'h7E, 8'hD0, 8'h7A, 8'h47, 8'h96, 8'hE5, 8'h26, 8'h80, 8'hAD, 8'hDF,
    8'hA1, 8'h30, 8'h37, 8'hAE, 8'h36, 8'h15, 8'h22, 8'h38, 8'hF4, 8'hA7, 8'h45, 8'h4C, 8'h81, 8'hE9, 8'h84, 8'h97,
    8'h35, 8'hCB, 8'hCE, 8'h3C, 8'h71, 8'h11, 8'hC7, 8'h89, 8'h75, 8'hFB, 8'hDA, 8'hF8, 8'h94, 8'h59, 8'h82, 8'hC4,
    8'hFF, 8'h49, 8'h39, 8'h67, 8'hC0, 8'hCF, 8'hD7, 8'hB8, 8'h0F, 8'h8E, 8'h42, 8'h23, 8'h91, 8'h6C, 8'hDB, 8'hA4,
    8'h34, 8'hF1, 8'h48, 8'hC2, 8'h6F, 8'h3D, 8'h2D, 8'h40, 8'hBE, 8'h3E, 8'hBC, 8'hC1, 8'hAA, 8'hBA, 8'h4E, 8'h55,
    8'h3B, 8'hDC, 8'h68, 8'h7F, 8'h9C, 8'hD8, 8'h4A, 8'h56, 8'h77, 8'hA0, 8'hED, 8'h46, 8'hB5, 8'h2B, 8'h65, 8'hFA,
    8'hE3, 8'hB9, 8'hB1, 8'h9F, 8'h5E, 8'hF9, 8'hE6, 8'hB2, 8'h31, 8'hEA, 8'h6D, 8'h5F, 8'hE4, 8'hF0, 8'hCD, 8'h88,
    8'h16, 8'h3A, 8'h58, 8'hD4, 8'h62, 8'h29, 8'h07, 8'h33, 8'hE8, 8'h1B, 8'h05, 8'h79, 8'h90, 8'h6A, 8'h2A, 8'h9A
  };

  localparam logic [7:0] S2Tab [256] = '{
    8'h38, 8'hE8, 8'h2D, 8'hA6, 8'hCF, 8'hDE, 8'hB3, 8'hB8, 8'hAF, 8'h60, 8'h55, 8'hC7, 8'h44, 8'h6F, 8'h6B, 8'h5B,
    8'hC3, 8'h62, 8'h33, 8'hB5, 8'h29, 8'hA0, 8'hE2, 8'hA7, 8'hD3, 8'h91, 8'h11, 8'h06, 8'h1C, 8'hBC, 8'h36, 8'h4B,
    8'hEF, 8'h88, 8'h6C, 8'hA8, 8'h17, 8'hC4, 8'h16, 8'hF4, 8'hC2, 8'h45, 8'hE1, 8'hD6, 8'h3F, 8'h3D, 8'h8E, 8'h98,
    8'h28, 8'h4E, 8'hF6, 8'h3E, 8'hA5, 8'hF9, 8'h0D, 8'hDF, 8'hD8, 8'h2B, 8'h66, 8'h7A, 8'h27, 8'h2F, 8'hF1, 8'h72,
    8'h42, 8'hD4, 8'h41, 8'hC0, 8'h73, 8'h67, 8'hAC, 8'h8B, 8'hF7, 8'hAD, 8'h80, 8'h1F, 8'hCA, 8'h2C, 8'hAA, 8'h34,
    8'hD2, 8'h0B, 8'hEE, 8'hE9, 8'h5D, 8'h94, 8'h18, 8'hF8, 8'h57, 8'hAE, 8'h08, 8'hC5, 8'h13, 8'hCD, 8'h86, 8'hB9,
    8'hFF, 8'h7D, 8'hC1, 8'h31, 8'hF5, 8'h8A, 8'h6A, 8'hB1, 8'hD1, 8'h20, 8'hD7, 8'h02, 8'h22, 8'h04, 8'h68, 8'h71,
    8'h07, 8'hDB, 8'h9D, 8'h99, 8'h61, 8'hBE, 8'hE6, 8'h59, 8'hDD, 8'h51, 8'h90, 8'hDC, 8'h9A, 8'hA3, 8'hAB, 8'hD0,
    8'h81, 8'h0F, 8'h47, 8'h1A, 8'hE3, 8'hEC, 8'h8D, 8'hBF, 8'h96, 8'h7B, 8'h5C, 8'hA2, 8'hA1, 8'h63, 8'h23, 8'h4D,
    8'hC8, 8'h9E, 8'h9C, 8'h3A, 8'h0C, 8'h2E, 8'hBA, 8'h6E, 8'h9F, 8'h5A, 8'hF2, 8'h92, 8'hF3, 8'h49, 8'h78, 8'hCC,
    8'h15, 8'hFB, 8'h70, 8'h75, 8'h7F, 8'h35, 8'h10, 8'h03, 8'h64, 8'h6D, 8'hC6, 8'h74, 8'hD5, 8'hB4, 8'hEA, 8'h09,
    8'h76, 8'h19, 8'hFE, 8'h40, 8'h12, 8'hE0, 8'hBD, 8'h05, 8'hFA, 8'h01, 8'hF0, 8'h2A, 8'h5E, 8'hA9, 8'h56, 8'h43,
    8'h85, 8'h14, 8'h89, 8'h9B, 8'hB0, 8'hE5, 8'h48, 8'h79, 8'h97, 8'hFC, 8'h1E, 8'h82, 8'h21, 8'h8C, 8'h1B, 8'h5F,
    8'h77, 8'h54, 8'hB2, 8'h1D, 8'h25, 8'h4F, 8'h00, 8'h46, 8'hED, 8'h58, 8'h52, 8'hEB, 8'h7E, 8'hDA, 8'hC9, 8'hFD,
    8'h30, 8'h95, 8'h65, 8'h3C, 8'hB6, 8'hE4, 8'hBB, 8'h7C, 8'h0E, 8'h50, 8'h39, 8'h26, 8'h32, 8'h84, 8'h69, 8'h93,
    8'h37, 8'hE7, 8'h24, 8'hA4, 8'hCB, 8'h53, 8'h0A, 8'h87, 8'hD9, 8'h4C, 8'h83, 8'h8F, 8'hCE, 8'h3B, 8'h4A, 8'hB7
  };

  logic [0:0]      state_q, state_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0][7:0] acc_q, acc_d;
  logic [7:0]      y;
  logic            in_fire, out_fire;

  // Even byte positions go through S1, odd through S2.
  assign y = idx_q[0] ? S2Tab[din] : S1Tab[din];

  assign din_ready  = (state_q == StLoad);
  assign dout_valid = (state_q == StEmit);
  assign dout       = dout_valid ? acc_q[idx_q] : 8'h00;

  assign in_fire  = (state_q == StLoad) && din_valid;
  assign out_fire = (state_q == StEmit) && dout_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    if (in_fire) begin
      for (int j = 0; j < 4; j++) begin
        acc_d[j] = acc_q[j] ^ (y & Masks[idx_q + 2'(j)]);
      end
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) state_d = StEmit;
    end else if (out_fire) begin
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        state_d = StLoad;
        acc_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StLoad;
      idx_q   <= 2'd0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_seed_g_serial.sv
// Scoreboard bench for seed_g_serial: a golden G model queues expected output bytes as
// input words complete; outputs are popped and compared as they transfer.
module tb_seed_g_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;

  always #5 clk = ~clk;

  seed_g_serial u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] sb[$];
  logic [7:0] got[$];
  logic [7:0] wbuf[4];
  int         widx = 0;

  logic [7:0] s1_t [256] = '{
    8'hA9, 8'h85, 8'hD6, 8'hD3, 8'h54, 8'h1D, 8'hAC, 8'h25, 8'h5D, 8'h43, 8'h18, 8'h1E, 8'h51, 8'hFC, 8'hCA, 8'h63,
    8'h28, 8'h44, 8'h20, 8'h9D, 8'hE0, 8'hE2, 8'hC8, 8'h17, 8'hA5, 8'h8F, 8'h03, 8'h7B, 8'hBB, 8'h13, 8'hD2, 8'hEE,
    8'h70, 8'h8C, 8'h3F, 8'hA8, 8'h32, 8'hDD, 8'hF6, 8'h74, 8'hEC, 8'h95, 8'h0B, 8'h57, 8'h5C, 8'h5B, 8'hBD, 8'h01,
    8'h24, 8'h1C, 8'h73, 8'h98, 8'h10, 8'hCC, 8'hF2, 8'hD9, 8'h2C, 8'hE7, 8'h72, 8'h83, 8'h9B, 8'hD1, 8'h86, 8'hC9,
    8'h60, 8'h50, 8'hA3, 8'hEB, 8'h0D, 8'hB6, 8'h9E, 8'h4F, 8'hB7, 8'h5A, 8'hC6, 8'h78, 8'hA6, 8'h12, 8'hAF, 8'hD5,
    8'h61, 8'hC3, 8'hB4, 8'h41, 8'h52, 8'h7D, 8'h8D, 8'h08, 8'h1F, 8'h99, 8'h00, 8'h19, 8'h04, 8'h53, 8'hF7, 8'hE1,
    8'hFD, 8'h76, 8'h2F, 8'h27, 8'hB0, 8'h8B, 8'h0E, 8'hAB, 8'hA2, 8'h6E, 8'h93, 8'h4D, 8'h69, 8'h7C, 8'h09, 8'h0A,
    8'hBF, 8'hEF, 8'hF3, 8'hC5, 8'h87, 8'h14, 8'hFE, 8'h64, 8'hDE, 8'h2E, 8'h4B, 8'h1A, 8'h06, 8'h21, 8'h6B, 8'h66,
    8'h02, 8'hF5, 8'h92, 8'h8A, 8'h0C, 8'hB3, 8'h7E, 8'hD0, 8'h7A, 8'h47, 8'h96, 8'hE5, 8'h26, 8'h80, 8'hAD, 8'hDF,
    8'hA1, 8'h30, 8'h37, 8'hAE, 8'h36, 8'h15, 8'h22, 8'h38, 8'hF4, 8'hA7, 8'h45, 8'h4C, 8'h81, 8'hE9, 8'h84, 8'h97,
    8'h35, 8'hCB, 8'hCE, 8'h3C, 8'h71, 8'h11, 8'hC7, 8'h89, 8'h75, 8'hFB, 8'hDA, 8'hF8, 8'h94, 8'h59, 8'h82, 8'hC4,
    8'hFF, 8'h49, 8'h39, 8'h67, 8'hC0, 8'hCF, 8'hD7, 8'hB8, 8'h0F, 8'h8E, 8'h42, 8'h23, 8'h91, 8'h6C, 8'hDB, 8'hA4,
    8'h34, 8'hF1, 8'h48, 8'hC2, 8'h6F, 8'h3D, 8'h2D, 8'h40, 8'hBE, 8'h3E, 8'hBC, 8'hC1, 8'hAA, 8'hBA, 8'h4E, 8'h55,
    8'h3B, 8'hDC, 8'h68, 8'h7F, 8'h9C, 8'hD8, 8'h4A, 8'h56, 8'h77, 8'hA0, 8'hED, 8'h46, 8'hB5, 8'h2B, 8'h65, 8'hFA,
    8'hE3, 8'hB9, 8'hB1, 8'h9F, 8'h5E, 8'hF9, 8'hE6, 8'hB2, 8'h31, 8'hEA, 8'h6D, 8'h5F, 8'hE4, 8'hF0, 8'hCD, 8'h88,
    8'h16, 8'h3A, 8'h58, 8'hD4, 8'h62, 8'h29, 8'h07, 8'h33, 8'hE8, 8'h1B, 8'h05, 8'h79, 8'h90, 8'h6A, 8'h2A, 8'h9A
  };

  logic [7:0] s2_t [256] = '{
    8'h38, 8'hE8, 8'h2D, 8'hA6, 8'hCF, 8'hDE, 8'hB3, 8'hB8, 8'hAF, 8'h60, 8'h55, 8'hC7, 8'h44, 8'h6F, 8'h6B, 8'h5B,
    8'hC3, 8'h62, 8'h33, 8'hB5, 8'h29, 8'hA0, 8'hE2, 8'hA7, 8'hD3, 8'h91, 8'h11, 8'h06, 8'h1C, 8'hBC, 8'h36, 8'h4B,
    8'hEF, 8'h88, 8'h6C, 8'hA8, 8'h17, 8'hC4, 8'h16, 8'hF4, 8'hC2, 8'h45, 8'hE1, 8'hD6, 8'h3F, 8'h3D, 8'h8E, 8'h98,
    8'h28, 8'h4E, 8'hF6, 8'h3E, 8'hA5, 8'hF9, 8'h0D, 8'hDF, 8'hD8, 8'h2B, 8'h66, 8'h7A, 8'h27, 8'h2F, 8'hF1, 8'h72,
    8'h42, 8'hD4, 8'h41, 8'hC0, 8'h73, 8'h67, 8'hAC, 8'h8B, 8'hF7, 8'hAD, 8'h80, 8'h1F, 8'hCA, 8'h2C, 8'hAA, 8'h34,
    8'hD2, 8'h0B, 8'hEE, 8'hE9, 8'h5D, 8'h94, 8'h18, 8'hF8, 8'h57, 8'hAE, 8'h08, 8'hC5, 8'h13, 8'hCD, 8'h86, 8'hB9,
    8'hFF, 8'h7D, 8'hC1, 8'h31, 8'hF5, 8'h8A, 8'h6A, 8'hB1, 8'hD1, 8'h20, 8'hD7, 8'h02, 8'h22, 8'h04, 8'h68, 8'h71,
    8'h07, 8'hDB, 8'h9D, 8'h99, 8'h61, 8'hBE, 8'hE6, 8'h59, 8'hDD, 8'h51, 8'h90, 8'hDC, 8'h9A, 8'hA3, 8'hAB, 8'hD0,
    8'h81, 8'h0F, 8'h47, 8'h1A, 8'hE3, 8'hEC, 8'h8D, 8'hBF, 8'h96, 8'h7B, 8'h5C, 8'hA2, 8'hA1, 8'h63, 8'h23, 8'h4D,
    8'hC8, 8'h9E, 8'h9C, 8'h3A, 8'h0C, 8'h2E, 8'hBA, 8'h6E, 8'h9F, 8'h5A, 8'hF2, 8'h92, 8'hF3, 8'h49, 8'h78, 8'hCC,
    8'h15, 8'hFB, 8'h70, 8'h75, 8'h7F, 8'h35, 8'h10, 8'h03, 8'h64, 8'h6D, 8'hC6, 8'h74, 8'hD5, 8'hB4, 8'hEA, 8'h09,
    8'h76, 8'h19, 8'hFE, 8'h40, 8'h12, 8'hE0, 8'hBD, 8'h05, 8'hFA, 8'h01, 8'hF0, 8'h2A, 8'h5E, 8'hA9, 8'h56, 8'h43,
    8'h85, 8'h14, 8'h89, 8'h9B, 8'hB0, 8'hE5, 8'h48, 8'h79, 8'h97, 8'hFC, 8'h1E, 8'h82, 8'h21, 8'h8C, 8'h1B, 8'h5F,
    8'h77, 8'h54, 8'hB2, 8'h1D, 8'h25, 8'h4F, 8'h00, 8'h46, 8'hED, 8'h58, 8'h52, 8'hEB, 8'h7E, 8'hDA, 8'hC9, 8'hFD,
    8'h30, 8'h95, 8'h65, 8'h3C, 8'hB6, 8'hE4, 8'hBB, 8'h7C, 8'h0E, 8'h50, 8'h39, 8'h26, 8'h32, 8'h84, 8'h69, 8'h93,
    8'h37, 8'hE7, 8'h24, 8'hA4, 8'hCB, 8'h53, 8'h0A, 8'h87, 8'hD9, 8'h4C, 8'h83, 8'h8F, 8'hCE, 8'h3B, 8'h4A, 8'hB7
  };

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Textbook SEED G: Z0 = Y0&m0 ^ Y1&m1 ^ Y2&m2 ^ Y3&m3, masks rotate for Z1..Z3.
  function automatic logic [31:0] g_model(input logic [31:0] x);
    logic [7:0] y0, y1, y2, y3, z0, z1, z2, z3;
    y0 = s1_t[x[7:0]];
    y1 = s2_t[x[15:8]];
    y2 = s1_t[x[23:16]];
    y3 = s2_t[x[31:24]];
    z0 = (y0 & 8'hFC) ^ (y1 & 8'hF3) ^ (y2 & 8'hCF) ^ (y3 & 8'h3F);
    z1 = (y0 & 8'hF3) ^ (y1 & 8'hCF) ^ (y2 & 8'h3F) ^ (y3 & 8'hFC);
    z2 = (y0 & 8'hCF) ^ (y1 & 8'h3F) ^ (y2 & 8'hFC) ^ (y3 & 8'hF3);
    z3 = (y0 & 8'h3F) ^ (y1 & 8'hFC) ^ (y2 & 8'hF3) ^ (y3 & 8'hCF);
    return {z3, z2, z1, z0};
  endfunction

  // One clock: drive on the falling edge, observe handshakes, then wait for the rising edge.
  task automatic cycle(input logic dv, input logic [7:0] d, input logic rdy,
                       output logic in_f, output logic out_f, output logic v_seen);
    logic [31:0] z;
    @(negedge clk);
    din_valid  = dv;
    din        = d;
    dout_ready = rdy;
    #1;
    in_f   = din_valid && din_ready;
    out_f  = dout_valid && dout_ready;
    v_seen = dout_valid;
    if (dout_valid) check_eq("ready_excl", din_ready, 1'b0);
    if (in_f) begin
      wbuf[widx] = din;
      widx++;
      if (widx == 4) begin
        z = g_model({wbuf[3], wbuf[2], wbuf[1], wbuf[0]});
        for (int k = 0; k < 4; k++) sb.push_back(z[8*k +: 8]);
        widx = 0;
      end
    end
    if (dout_valid) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", dout_valid, 1'b0);
      end else if (out_f) begin
        check_eq("dout", dout, sb.pop_front());
        got.push_back(dout);
      end else begin
        check_eq("dout_hold", dout, sb[0]);
      end
    end
    @(posedge clk);
  endtask

  task automatic run_word(input logic [31:0] x, input int gap, input int vpct, input int rpct,
                          input int stall_idx, input int stall_len, input bit junk,
                          output int cyc);
    int sent = 0, rcvd = 0, gapc = 0, stallc = 0, budget = 400;
    bit lat = 0;
    logic dv, rdy, in_f, out_f, v_seen;
    logic [7:0] d;
    cyc = 0;
    while (rcvd < 4 && budget > 0) begin
      d  = 8'($urandom);
      dv = 1'b0;
      if (sent < 4) begin
        if (gapc == 0 && $urandom_range(99) < vpct) begin
          dv = 1'b1;
          d  = x[8*sent +: 8];
        end
      end else if (junk) begin
        dv = 1'b1;
      end
      rdy = ($urandom_range(99) < rpct);
      if (rcvd == stall_idx && stallc < stall_len) rdy = 1'b0;
      cycle(dv, d, rdy, in_f, out_f, v_seen);
      if (lat) begin
        check_eq("latency", v_seen, 1'b1);
        lat = 0;
      end
      if (in_f) begin
        sent++;
        gapc = gap;
        if (sent == 4) lat = 1;
      end else if (gapc > 0 && sent < 4) begin
        gapc--;
      end
      if (v_seen && !rdy && rcvd == stall_idx) stallc++;
      if (out_f) rcvd++;
      budget--;
      cyc++;
    end
    if (rcvd < 4) check_eq("timeout", rcvd, 4);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    #1;
    check_eq({tag, "_din_ready"}, din_ready, 1'b1);
    check_eq({tag, "_dout_valid"}, dout_valid, 1'b0);
  endtask

  task automatic check_zero_out(input string tag, input int base);
    logic [31:0] exp_w;
    exp_w = 32'hB829B829;
    if (got.size() < base + 4) begin
      check_eq({tag, "_count"}, got.size(), base + 4);
    end else begin
      for (int k = 0; k < 4; k++) check_eq(tag, got[base + k], exp_w[8*k +: 8]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    #1;
    check_eq("rst_dout_valid", dout_valid, 1'b0);
    check_eq("rst_dout", dout, 8'h00);
    check_eq("rst_din_ready", din_ready, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    widx = 0;
  endtask

  initial begin
    int cyc, base;
    logic in_f, out_f, v_seen;

    do_reset();
    idle_check("post_reset");

    // Zero word, no stalls: known output and one word per 8 cycles.
    base = got.size();
    run_word(32'h0, 0, 100, 100, -1, 0, 1'b0, cyc);
    check_zero_out("zero_b2b", base);
    check_eq("throughput_cycles", cyc, 8);
    idle_check("after_z3");

    // Gapped input.
    base = got.size();
    run_word(32'h0, 2, 100, 100, -1, 0, 1'b0, cyc);
    check_zero_out("zero_gap", base);
    idle_check("after_gap");

    // Stall on Z1 for 5 cycles.
    base = got.size();
    run_word(32'h0, 0, 100, 100, 1, 5, 1'b0, cyc);
    check_zero_out("zero_stall", base);
    check_eq("stall_cycles", cyc, 13);
    idle_check("after_stall");

    // Reset mid-word after X1.
    cycle(1'b1, 8'h5A, 1'b1, in_f, out_f, v_seen);
    check_eq("x0_accept", in_f, 1'b1);
    cycle(1'b1, 8'hC3, 1'b1, in_f, out_f, v_seen);
    check_eq("x1_accept", in_f, 1'b1);
    do_reset();
    base = got.size();
    run_word(32'h0, 0, 100, 100, -1, 0, 1'b0, cyc);
    check_zero_out("zero_after_rst", base);
    idle_check("after_rst_word");

    // Junk on din during EMIT, with a stall so it lingers.
    run_word(32'h1234ABCD, 0, 100, 100, 2, 3, 1'b1, cyc);
    check_eq("junk_no_stray", widx, 0);
    idle_check("after_junk");

    for (int w = 0; w < 1000; w++) begin
      run_word($urandom, $urandom_range(1), 70, 70, -1, 0, $urandom_range(1) == 1, cyc);
    end
    check_eq("sb_drained", sb.size(), 0);
    idle_check("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
